// File: rtl/axis_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// axis_rr_arbiter_if : merged-stream bundle (CHANNELS inputs, one output)
// Rev 1.0
// ============================================================================
interface axis_rr_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 4,
   parameter int CHAN_WIDTH = 2
);
   logic [CHANNELS*DATA_WIDTH-1:0] idata;
   logic [CHANNELS-1:0]            ivalid;
   logic [CHANNELS-1:0]            ilast;
   logic [CHANNELS-1:0]            iready;
   logic [DATA_WIDTH-1:0]          odata;
   logic                           olast;
   logic [CHAN_WIDTH-1:0]          ochan;
   logic                           ovalid;
   logic                           oready;

   // master: the arbiter; slave: the attached sources and sink
   modport master (
      input  idata, ivalid, ilast, oready,
      output iready, odata, olast, ochan, ovalid
   );
   modport slave (
      output idata, ivalid, ilast, oready,
      input  iready, odata, olast, ochan, ovalid
   );
endinterface
`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
`default_nettype none
// ============================================================================
// axis_rr_arbiter : packet-aware round-robin merge into a registered stream
// Rev 1.0
// ============================================================================
module axis_rr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int CHANNELS   = 4,
   parameter int CHAN_WIDTH = 2
) (
   input wire logic          clock,
   input wire logic          resetn,
   axis_rr_arbiter_if.master bus
);
   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CHAN_WIDTH-1:0]   grant_q, grant_d;
   logic [CHAN_WIDTH-1:0]   ptr_q, ptr_d;
   logic                    ovalid_q, ovalid_d;
   logic [DATA_WIDTH-1:0]   odata_q, odata_d;
   logic                    olast_q, olast_d;
   logic [CHAN_WIDTH-1:0]   ochan_q, ochan_d;

   logic [CHAN_WIDTH-1:0]   sel;
   logic [CHAN_WIDTH:0]     sum;
   logic [CHAN_WIDTH-1:0]   cand;
   logic                    have_sel;
   logic                    sel_valid;
   logic                    sel_last;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    load;
   logic                    give;
   logic                    accept;
   logic [CHANNELS-1:0]     iready;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      ptr_d    = ptr_q;
      ovalid_d = ovalid_q;
      odata_d  = odata_q;
      olast_d  = olast_q;
      ochan_d  = ochan_q;
      sel      = grant_q;
      have_sel = (state_q == ST_LOCKED);
      sum      = '0;
      cand     = '0;

      // Rotating scan from ptr; the sum never exceeds 2*CHANNELS-2 so one subtract wraps it
      if (state_q == ST_IDLE) begin
         for (int i = 0; i < CHANNELS; i++) begin
            sum = {1'b0, ptr_q} + (CHAN_WIDTH+1)'(i);
            if (sum >= (CHAN_WIDTH+1)'(CHANNELS))
               sum = sum - (CHAN_WIDTH+1)'(CHANNELS);
            cand = sum[CHAN_WIDTH-1:0];
            if (!have_sel && bus.ivalid[cand]) begin
               have_sel = 1'b1;
               sel      = cand;
            end
         end
      end

      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (sel == CHAN_WIDTH'(k)) begin
            sel_valid = bus.ivalid[k];
            sel_last  = bus.ilast[k];
            sel_data  = bus.idata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end

      load   = !ovalid_q || bus.oready;
      // A locked grant keeps ready up even while its source is idle, so no one else sneaks in
      give   = resetn && have_sel && load;
      accept = give && sel_valid;
      for (int k = 0; k < CHANNELS; k++)
         iready[k] = give && (sel == CHAN_WIDTH'(k));

      if (accept) begin
         ovalid_d = 1'b1;
         odata_d  = sel_data;
         olast_d  = sel_last;
         ochan_d  = sel;
         if (sel_last) begin
            state_d = ST_IDLE;
            ptr_d   = (sel == CHAN_WIDTH'(CHANNELS-1)) ? '0 : sel + CHAN_WIDTH'(1);
         end else begin
            state_d = ST_LOCKED;
            grant_d = sel;
         end
      end else if (load) begin
         ovalid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         ptr_q    <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         ptr_q    <= ptr_d;
         ovalid_q <= ovalid_d;
      end
   end

   // Payload is qualified by ovalid, so it carries no reset
   always_ff @(posedge clock) begin
      odata_q <= odata_d;
      olast_q <= olast_d;
      ochan_q <= ochan_d;
   end

   assign bus.iready = iready;
   assign bus.odata  = odata_q;
   assign bus.olast  = olast_q;
   assign bus.ochan  = ochan_q;
   assign bus.ovalid = ovalid_q;

`ifdef FORMAL
   logic r_f_past_valid = 1'b0;
   always @(posedge clock)
      r_f_past_valid <= 1'b1;

   always @(posedge clock) begin
      if (!r_f_past_valid)
         assume (!resetn);
      if (resetn) begin
         assert ($onehot0(iready));
         assert (state_q == ST_IDLE || int'(grant_q) < CHANNELS);
         if (r_f_past_valid && $past(resetn) && $past(ovalid_q && !bus.oready))
            assert (ovalid_q && odata_q == $past(odata_q) &&
                    olast_q == $past(olast_q) && ochan_q == $past(ochan_q));
      end
   end
`endif
endmodule
`default_nettype wire
